// File: rtl/minsoc_wb_byte_ram_bridge.sv
// Wishbone classic 32-bit slave in front of an 8-bit single-port RAM.
// Each word access becomes four fixed byte-lane slots (lane 0 = bits 31:24),
// followed by a data-capture cycle and a one-cycle registered ack.
module minsoc_wb_byte_ram_bridge #(
  parameter int aw = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          ram_ce,
  output logic          ram_we,
  output logic          ram_oe,
  output logic [aw-1:0] ram_addr,
  output logic [7:0]    ram_di,
  input  logic [7:0]    ram_doq
);

  typedef enum logic [1:0] {IDLE, RUN, FIN, ACK} state_t;

  state_t       state_q, state_d;
  logic [1:0]   lane_q, lane_d;
  logic [aw-3:0] adr_q;
  logic [3:0]   sel_q;
  logic [31:0]  dat_q;
  logic         we_q;
  logic [31:0]  rbuf_q, rbuf_d;
  logic         rd_pend_q;
  logic [1:0]   rd_lane_q;
  logic         accept;
  logic         active;
  logic         fin_ok;

  // Upper address bits alias; low two bits are lane-generated internally.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:aw], wb_adr_i[1:0]};

  assign accept = (state_q == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign active = (state_q == RUN) || (state_q == FIN);
  assign fin_ok = (state_q == FIN) && wb_cyc_i;

  // State and lane counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state logic, RAM strobes and read-byte merge.
  // Lane L addresses byte L of the word; its data/sel bit index is 3-L == ~L.
  // Strobes are gated by cyc (abort) and rst so dropped lanes never issue.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    ram_addr = {adr_q, lane_q};
    ram_di   = dat_q[{~lane_q, 3'b000} +: 8];
    rbuf_d   = rbuf_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        lane_d  = 2'd0;
      end
      RUN: if (!wb_cyc_i) begin
        state_d = IDLE;
      end else begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) state_d = FIN;
      end
      FIN: state_d = wb_cyc_i ? ACK : IDLE;
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == RUN && wb_cyc_i && !rst && sel_q[~lane_q]) begin
      ram_ce = 1'b1;
      ram_we = we_q;
    end
    ram_oe = active && !we_q && !rst;
    if (rd_pend_q) rbuf_d[{~rd_lane_q, 3'b000} +: 8] = ram_doq;
  end

  // Capture registers, read buffer, and registered Wishbone response.
  // A read issued in cycle n is merged at the end of cycle n+1, so the
  // lane-3 byte lands during FIN and is folded straight into wb_dat_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q     <= '0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      we_q      <= 1'b0;
      rbuf_q    <= 32'd0;
      rd_pend_q <= 1'b0;
      rd_lane_q <= 2'd0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 32'd0;
    end else begin
      rd_pend_q <= ram_ce && !ram_we;
      rd_lane_q <= lane_q;
      wb_ack_o  <= fin_ok;
      if (accept) begin
        adr_q  <= wb_adr_i[aw-1:2];
        sel_q  <= wb_sel_i;
        dat_q  <= wb_dat_i;
        we_q   <= wb_we_i;
        rbuf_q <= 32'd0;
      end else begin
        rbuf_q <= rbuf_d;
      end
      if (fin_ok) wb_dat_o <= rbuf_d;
    end
  end

endmodule
